// File: rtl/io_write.sv
// I/O write-port stage: stage-1 readiness check, stage-2 cancel, stage-3 strobe and per-port data register.
// Latency: addr_1 -> write_enable/data_out is 3 cycles; EmptyFull_masked is combinational from addr_1.
// Backpressure: none absorbed here; a full port raises EmptyFull_masked so the pipeline stalls/annuls upstream.
module io_write #(
    parameter int WORD_WIDTH            = 36,
    parameter int ADDR_WIDTH            = 10,
    parameter int WRITE_PORT_COUNT      = 4,
    parameter int WRITE_PORT_BASE_ADDR  = 0,
    parameter int WRITE_PORT_ADDR_WIDTH = 2
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic [ADDR_WIDTH-1:0]                 addr_1,
    input  logic [ADDR_WIDTH-1:0]                 addr_3,
    input  logic [WRITE_PORT_COUNT-1:0]           EmptyFull,
    input  logic                                  IO_ready,
    input  logic [WORD_WIDTH-1:0]                 data_in,
    output logic                                  EmptyFull_masked,
    output logic [WRITE_PORT_COUNT-1:0]           write_enable,
    output logic [WRITE_PORT_COUNT*WORD_WIDTH-1:0] data_out
);

    localparam int PW = WRITE_PORT_ADDR_WIDTH;
    localparam int NP = 2 ** PW;
    localparam logic [ADDR_WIDTH:0]   BASE_X  = (ADDR_WIDTH+1)'(WRITE_PORT_BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] COUNT_X = ADDR_WIDTH'(WRITE_PORT_COUNT);

    // Offsets carry one extra bit so a borrow marks "below the window base".
    logic [ADDR_WIDTH:0]         off_1, off_3;
    logic                        is_io_1, is_io_3;
    logic [PW-1:0]               port_1, port_3;
    logic [NP-1:0]               ef_ext;
    logic                        io_1_d, io_1_q;
    logic                        io_2_d, io_2_q;
    logic [WRITE_PORT_COUNT-1:0] we_d, we_q;
    logic [WORD_WIDTH-1:0]       data_q [WRITE_PORT_COUNT];

    // Window decode of both the raw (stage 1) and translated (stage 3) address.
    always_comb begin
        off_1   = {1'b0, addr_1} - BASE_X;
        off_3   = {1'b0, addr_3} - BASE_X;
        is_io_1 = !off_1[ADDR_WIDTH] && (off_1[ADDR_WIDTH-1:0] < COUNT_X);
        is_io_3 = !off_3[ADDR_WIDTH] && (off_3[ADDR_WIDTH-1:0] < COUNT_X);
        port_1  = off_1[PW-1:0];
        port_3  = off_3[PW-1:0];
        // Pad the status vector to the full select range so any port index is a legal lookup.
        ef_ext  = '0;
        ef_ext[WRITE_PORT_COUNT-1:0] = EmptyFull;
    end

    // Stage decisions: full-port flag, ready-to-write pipeline bits, stage-3 strobe select.
    always_comb begin
        EmptyFull_masked = reset_n & is_io_1 & ~ef_ext[port_1];
        io_1_d           = is_io_1 & ef_ext[port_1];
        io_2_d           = io_1_q & IO_ready;
        we_d             = '0;
        for (int p = 0; p < WRITE_PORT_COUNT; p++) begin
            we_d[p] = io_2_q & is_io_3 & (port_3 == PW'(p));
        end
    end

    // Pipeline state, one-cycle strobe and per-port held write data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            io_1_q <= 1'b0;
            io_2_q <= 1'b0;
            we_q   <= '0;
            for (int p = 0; p < WRITE_PORT_COUNT; p++) begin
                data_q[p] <= '0;
            end
        end else begin
            io_1_q <= io_1_d;
            io_2_q <= io_2_d;
            we_q   <= we_d;
            for (int p = 0; p < WRITE_PORT_COUNT; p++) begin
                if (we_d[p]) begin
                    data_q[p] <= data_in;
                end
            end
        end
    end

    assign write_enable = we_q;

    for (genvar g = 0; g < WRITE_PORT_COUNT; g++) begin : g_dout
        assign data_out[g*WORD_WIDTH +: WORD_WIDTH] = data_q[g];
    end

endmodule
